fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the cotm32 pipeline. It generalises per-operand bypass selection to N read ports and M forwarding stages, and adds three things:
- load-use stall detection for stages whose result is not yet ready;
- a per-register scoreboard for long-latency units (mul/div) with completion-bus bypass;
- WAW protection and an outstanding-operation limit.

It sits between decode/issue (ID/EX consumer) and the EX-side bypass muxes and pipeline control.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; AW = $clog2(NUM_REGS)
- NUM_RPORTS, 2, source operands checked per instruction
- NUM_FWD_STAGES, 2, forwarding stages; index 0 is youngest (EX/MEM), 1 is MEM/WB
- MAX_OUTSTANDING, 4, long-latency ops in flight; CW = $clog2(MAX_OUTSTANDING+1)
- SW = $clog2(NUM_FWD_STAGES+2), select width (derived)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_rs_addr  in  NUM_RPORTS*AW  consumer source register addresses, port p at [p*AW +: AW]
- i_rs_used  in  NUM_RPORTS  port p is actually read
- i_dst_addr  in  AW  consumer destination
- i_dst_we  in  1  consumer writes i_dst_addr
- i_stg_rd_addr  in  NUM_FWD_STAGES*AW  destination per stage
- i_stg_we, i_stg_valid, i_stg_data_rdy  in  NUM_FWD_STAGES each  per-stage write-enable, valid, result-available
- i_issue_valid  in  1  consumer is a long-latency op requesting issue
- i_issue_rd  in  AW  its destination
- i_cmpl_valid  in  1  long-latency unit completes this cycle
- i_cmpl_rd  in  AW  completing destination
- i_flush  in  1  consumer is squashed this cycle
- o_fwd_sel  out  NUM_RPORTS*SW  per port: 0 none, k in 1..NUM_FWD_STAGES = stage k-1, NUM_FWD_STAGES+1 = completion bus
- o_stall  out  1  hold consumer in ID/EX
- o_issue_accept  out  1  long-latency issue taken this cycle
- o_busy  out  NUM_REGS  scoreboard bits
- o_outstanding  out  CW  in-flight count
- o_full  out  1  o_outstanding == MAX_OUTSTANDING
- o_cmpl_err  out  1  sticky: completion for a non-busy register

## Operation
- A stage k matches port p when all of the following hold: i_rs_used[p], i_stg_valid[k], i_stg_we[k], i_stg_rd_addr[k] != 0, and i_stg_rd_addr[k] == rs[p].
- Selection for port p is the lowest matching k (youngest wins):
  - if i_stg_data_rdy[k]=1, sel = k+1;
  - otherwise sel = 0 and a load-use stall is raised.
- If no stage matches, rs[p] != 0, busy[rs[p]], and i_cmpl_valid with i_cmpl_rd == rs[p]: sel = NUM_FWD_STAGES+1 and no stall.
- If no stage matches and busy[rs[p]] without a matching completion: sel = 0 and a RAW stall is raised.
- WAW stall: i_dst_we && i_dst_addr != 0 && busy[i_dst_addr] && !(i_cmpl_valid && i_cmpl_rd == i_dst_addr).
- Full stall: i_issue_valid && o_full && !i_cmpl_valid.
- o_stall is the OR of all stall conditions, gated to 0 when i_flush=1.
- o_issue_accept = i_issue_valid && !o_stall && !i_flush.
- Scoreboard update at the clock edge:
  - completion with busy[i_cmpl_rd] clears the bit and decrements the count;
  - completion for a non-busy register changes nothing and sets o_cmpl_err;
  - an accepted issue with i_issue_rd != 0 sets the bit and increments the count;
  - an accepted issue with rd = 0 is accepted but not tracked.
- Simultaneous completion and issue to the same register: the bit stays 1 and the count is unchanged (issue wins).
- Simultaneous completion and issue to different registers: the count is unchanged.
- The count never exceeds MAX_OUTSTANDING and never underflows. busy[0] is always 0.
- i_flush does not clear the scoreboard. In-flight ops still complete.

## Timing
- o_fwd_sel, o_stall and o_issue_accept are combinational, same cycle as the inputs.
- o_busy, o_outstanding, o_full and o_cmpl_err are registered. Updates become visible the cycle after the event.
- Issue-to-busy latency is 1 cycle. A dependent consumer in the following cycle sees busy=1 and stalls.
- Reset (i_rst=1 at the edge) clears o_busy, o_outstanding and o_cmpl_err to 0, so o_full=0. Reset mid-operation discards all pending state.
- While i_rst=1 the combinational outputs still follow the inputs and the registered (zero) state.
- With all inputs idle after reset: o_fwd_sel=0, o_stall=0, o_issue_accept=0.

## Test plan
- Stage 0 and stage 1 both write x5, both ready, rs1=x5 -> sel port0 = 1 (stage 0); with stage 0 invalid -> sel = 2.
- Stage 0 writes x7 with data_rdy=0, rs2=x7 -> o_stall=1, sel port1 = 0; next cycle data_rdy=1 -> stall 0, sel = 1.
- Issue div to x9 (accept=1) -> next cycle busy[9]=1, outstanding=1; consumer reads x9 -> stall; i_cmpl_valid with rd=9 that same cycle -> stall 0, sel = 3, then busy[9]=0, count 0.
- Issue 4 ops to x1..x4 -> o_full=1; 5th issue -> stall, accept=0; 5th issue with a completion in the same cycle -> accepted, count stays 4.
- Consumer with dst=x3 while busy[3] -> WAW stall; i_flush=1 -> stall 0, accept 0, busy unchanged.
- Completion for x12 while not busy -> o_cmpl_err=1 next cycle, count unchanged; i_rst -> all registered outputs 0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard unit: per-port bypass selection across forwarding stages,
// load-use and RAW/WAW stall detection, and a scoreboard for long-latency ops.
module fwd_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int NUM_RPORTS      = 2,
  parameter int NUM_FWD_STAGES  = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int SW = $clog2(NUM_FWD_STAGES + 2)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_RPORTS*AW-1:0]     i_rs_addr,
  input  logic [NUM_RPORTS-1:0]        i_rs_used,
  input  logic [AW-1:0]                i_dst_addr,
  input  logic                         i_dst_we,
  input  logic [NUM_FWD_STAGES*AW-1:0] i_stg_rd_addr,
  input  logic [NUM_FWD_STAGES-1:0]    i_stg_we,
  input  logic [NUM_FWD_STAGES-1:0]    i_stg_valid,
  input  logic [NUM_FWD_STAGES-1:0]    i_stg_data_rdy,
  input  logic                         i_issue_valid,
  input  logic [AW-1:0]                i_issue_rd,
  input  logic                         i_cmpl_valid,
  input  logic [AW-1:0]                i_cmpl_rd,
  input  logic                         i_flush,
  output logic [NUM_RPORTS*SW-1:0]     o_fwd_sel,
  output logic                         o_stall,
  output logic                         o_issue_accept,
  output logic [NUM_REGS-1:0]          o_busy,
  output logic [CW-1:0]                o_outstanding,
  output logic                         o_full,
  output logic                         o_cmpl_err
);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;
  logic [NUM_RPORTS-1:0] port_stall;
  logic                  full;
  logic                  waw_stall;
  logic                  full_stall;
  logic                  cmpl_hit;
  logic                  issue_new;
  logic                  room;

  assign full = (count_q == CW'(MAX_OUTSTANDING));

  generate
    for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_port
      logic [AW-1:0] rs;
      logic [SW-1:0] sel;
      logic          stall;
      logic          found;

      assign rs = i_rs_addr[gi*AW +: AW];

      // Youngest matching stage decides; a not-ready result blocks older stages.
      always_comb begin
        sel   = '0;
        stall = 1'b0;
        found = 1'b0;
        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
          if (!found && i_rs_used[gi] && i_stg_valid[k] && i_stg_we[k] &&
              (i_stg_rd_addr[k*AW +: AW] != '0) &&
              (i_stg_rd_addr[k*AW +: AW] == rs)) begin
            found = 1'b1;
            if (i_stg_data_rdy[k]) begin
              sel = SW'(k + 1);
            end else begin
              stall = 1'b1;
            end
          end
        end
        if (!found && i_rs_used[gi] && (rs != '0) && busy_q[rs]) begin
          if (i_cmpl_valid && (i_cmpl_rd == rs)) begin
            sel = SW'(NUM_FWD_STAGES + 1);
          end else begin
            stall = 1'b1;
          end
        end
      end

      assign o_fwd_sel[gi*SW +: SW] = sel;
      assign port_stall[gi]         = stall;
    end
  endgenerate

  assign waw_stall  = i_dst_we && (i_dst_addr != '0) && busy_q[i_dst_addr] &&
                      !(i_cmpl_valid && (i_cmpl_rd == i_dst_addr));
  assign full_stall = i_issue_valid && full && !i_cmpl_valid;

  assign o_stall        = (|port_stall || waw_stall || full_stall) && !i_flush;
  assign o_issue_accept = i_issue_valid && !o_stall && !i_flush;

  // An issue is tracked only if it adds a new busy register and a slot is free
  // after this cycle's completion, keeping count equal to the number of busy bits.
  always_comb begin
    cmpl_hit  = i_cmpl_valid && busy_q[i_cmpl_rd];
    room      = !full || cmpl_hit;
    issue_new = o_issue_accept && (i_issue_rd != '0) && room &&
                (!busy_q[i_issue_rd] || (cmpl_hit && (i_cmpl_rd == i_issue_rd)));

    busy_d  = busy_q;
    count_d = count_q;
    err_d   = err_q;

    if (i_cmpl_valid && !busy_q[i_cmpl_rd]) begin
      err_d = 1'b1;
    end
    if (cmpl_hit) begin
      busy_d[i_cmpl_rd] = 1'b0;
    end
    if (issue_new) begin
      busy_d[i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    count_d   = count_q - CW'(cmpl_hit) + CW'(issue_new);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_outstanding = count_q;
  assign o_full        = full;
  assign o_cmpl_err    = err_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: vector table, directed multi-cycle sequences and
// randomized cycles checked against a register-set reference model.
module tb_fwd_scoreboard;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int NS = 2;
  localparam int MO = 4;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int CW = 3;

  logic              clk;
  logic              rst;
  logic [NP*AW-1:0]  rs_addr;
  logic [NP-1:0]     rs_used;
  logic [AW-1:0]     dst_addr;
  logic              dst_we;
  logic [NS*AW-1:0]  stg_addr;
  logic [NS-1:0]     stg_we, stg_valid, stg_rdy;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              cmpl_valid;
  logic [AW-1:0]     cmpl_rd;
  logic              flush;
  logic [NP*SW-1:0]  fwd_sel;
  logic              stall;
  logic              issue_accept;
  logic [NR-1:0]     busy;
  logic [CW-1:0]     outstanding;
  logic              full;
  logic              cmpl_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit m_busy[NR];
  bit m_err;

  fwd_scoreboard dut (
    .i_clk(clk), .i_rst(rst),
    .i_rs_addr(rs_addr), .i_rs_used(rs_used),
    .i_dst_addr(dst_addr), .i_dst_we(dst_we),
    .i_stg_rd_addr(stg_addr), .i_stg_we(stg_we), .i_stg_valid(stg_valid),
    .i_stg_data_rdy(stg_rdy),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_cmpl_valid(cmpl_valid), .i_cmpl_rd(cmpl_rd),
    .i_flush(flush),
    .o_fwd_sel(fwd_sel), .o_stall(stall), .o_issue_accept(issue_accept),
    .o_busy(busy), .o_outstanding(outstanding), .o_full(full),
    .o_cmpl_err(cmpl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Reference: expected combinational outputs from the rules and the model's busy set.
  task automatic model_comb(output logic [NP*SW-1:0] e_sel, output logic e_stall,
                            output logic e_acc);
    logic hazard = 1'b0;
    logic waw, fst;
    e_sel = '0;
    for (int p = 0; p < NP; p++) begin
      logic [AW-1:0] r = rs_addr[p*AW +: AW];
      int hit = -1;
      if (rs_used[p] && r != 0)
        for (int k = NS - 1; k >= 0; k--)
          if (stg_valid[k] && stg_we[k] && stg_addr[k*AW +: AW] == r) hit = k;
      if (hit >= 0) begin
        if (stg_rdy[hit]) e_sel[p*SW +: SW] = SW'(hit + 1);
        else hazard = 1'b1;
      end else if (rs_used[p] && m_busy[r]) begin
        if (cmpl_valid && cmpl_rd == r) e_sel[p*SW +: SW] = SW'(NS + 1);
        else hazard = 1'b1;
      end
    end
    waw = dst_we && dst_addr != 0 && m_busy[dst_addr] && !(cmpl_valid && cmpl_rd == dst_addr);
    fst = issue_valid && (m_count() == MO) && !cmpl_valid;
    e_stall = (hazard || waw || fst) && !flush;
    e_acc   = issue_valid && !e_stall && !flush;
  endtask

  task automatic model_edge();
    logic [NP*SW-1:0] s;
    logic st, acc;
    model_comb(s, st, acc);
    if (rst) begin
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
      m_err = 1'b0;
    end else begin
      if (cmpl_valid) begin
        if (m_busy[cmpl_rd]) m_busy[cmpl_rd] = 1'b0;
        else m_err = 1'b1;
      end
      if (acc && issue_rd != 0 && m_count() < MO) m_busy[issue_rd] = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic clear_in();
    rs_addr = '0; rs_used = '0; dst_addr = '0; dst_we = 1'b0;
    stg_addr = '0; stg_we = '0; stg_valid = '0; stg_rdy = '0;
    issue_valid = 1'b0; issue_rd = '0; cmpl_valid = 1'b0; cmpl_rd = '0;
    flush = 1'b0;
  endtask

  typedef struct {
    logic [NP*AW-1:0] rs_addr;   // {port1, port0}
    logic [NP-1:0]    rs_used;
    logic [NS*AW-1:0] stg_addr;  // {stage1, stage0}
    logic [NS-1:0]    we;
    logic [NS-1:0]    valid;
    logic [NS-1:0]    rdy;
    logic [NP*SW-1:0] exp_sel;
    logic             exp_stall;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [NP*SW-1:0] e_sel;
    logic e_stall, e_acc;

    vecs[0] = '{{5'd0, 5'd5}, 2'b01, {5'd5, 5'd5}, 2'b11, 2'b11, 2'b11, 4'b0001, 1'b0};
    vecs[1] = '{{5'd0, 5'd5}, 2'b01, {5'd5, 5'd5}, 2'b11, 2'b10, 2'b11, 4'b0010, 1'b0};
    vecs[2] = '{{5'd7, 5'd0}, 2'b10, {5'd0, 5'd7}, 2'b01, 2'b01, 2'b00, 4'b0000, 1'b1};
    vecs[3] = '{{5'd7, 5'd0}, 2'b10, {5'd0, 5'd7}, 2'b01, 2'b01, 2'b01, 4'b0100, 1'b0};
    vecs[4] = '{{5'd7, 5'd7}, 2'b00, {5'd0, 5'd7}, 2'b01, 2'b01, 2'b00, 4'b0000, 1'b0};
    vecs[5] = '{{5'd0, 5'd0}, 2'b11, {5'd0, 5'd0}, 2'b11, 2'b11, 2'b11, 4'b0000, 1'b0};
    vecs[6] = '{{5'd0, 5'd5}, 2'b01, {5'd5, 5'd5}, 2'b11, 2'b11, 2'b10, 4'b0000, 1'b1};
    vecs[7] = '{{5'd0, 5'd5}, 2'b01, {5'd5, 5'd5}, 2'b10, 2'b11, 2'b11, 4'b0010, 1'b0};
    vecs[8] = '{{5'd9, 5'd5}, 2'b11, {5'd9, 5'd5}, 2'b11, 2'b11, 2'b11, 4'b1001, 1'b0};

    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state with idle inputs
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_cnt", outstanding, 0);
    chk("rst_full", full, 0);
    chk("rst_err", cmpl_err, 0);
    chk("idle_sel", fwd_sel, 0);
    chk("idle_stall", stall, 0);
    chk("idle_acc", issue_accept, 0);
    $display("reset: busy=%h cnt=%0d stall=%b", busy, outstanding, stall);
    tick();

    // Stage forwarding table (empty scoreboard)
    foreach (vecs[i]) begin
      clear_in();
      rs_addr = vecs[i].rs_addr; rs_used = vecs[i].rs_used;
      stg_addr = vecs[i].stg_addr; stg_we = vecs[i].we;
      stg_valid = vecs[i].valid; stg_rdy = vecs[i].rdy;
      settle();
      chk($sformatf("vec%0d_sel", i), fwd_sel, vecs[i].exp_sel);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_acc", i), issue_accept, 0);
      $display("vec %0d: sel=%h stall=%b", i, fwd_sel, stall);
      tick();
    end

    // Long-latency issue, RAW stall, completion bypass
    clear_in(); issue_valid = 1'b1; issue_rd = 5'd9;
    settle();
    chk("div_acc", issue_accept, 1);
    $display("issue x9: acc=%b", issue_accept);
    tick();
    clear_in(); rs_addr = {5'd0, 5'd9}; rs_used = 2'b01;
    settle();
    chk("div_busy9", busy[9], 1);
    chk("div_cnt1", outstanding, 1);
    chk("raw_stall", stall, 1);
    chk("raw_sel", fwd_sel, 0);
    cmpl_valid = 1'b1; cmpl_rd = 5'd9;
    #1;
    chk("byp_stall", stall, 0);
    chk("byp_sel", fwd_sel, 4'b0011);
    $display("read x9 with cmpl: sel=%h stall=%b", fwd_sel, stall);
    tick();
    clear_in();
    settle();
    chk("cmpl_busy9", busy[9], 0);
    chk("cmpl_cnt0", outstanding, 0);
    tick();

    // Fill to the outstanding limit
    for (int r = 1; r <= 4; r++) begin
      clear_in(); issue_valid = 1'b1; issue_rd = AW'(r);
      settle();
      chk($sformatf("fill%0d_acc", r), issue_accept, 1);
      $display("issue x%0d: acc=%b cnt=%0d", r, issue_accept, outstanding);
      tick();
    end
    clear_in(); issue_valid = 1'b1; issue_rd = 5'd10;
    settle();
    chk("full_flag", full, 1);
    chk("full_cnt", outstanding, 4);
    chk("full_stall", stall, 1);
    chk("full_acc", issue_accept, 0);
    cmpl_valid = 1'b1; cmpl_rd = 5'd1;
    #1;
    chk("full_cmpl_stall", stall, 0);
    chk("full_cmpl_acc", issue_accept, 1);
    $display("issue x10 with cmpl x1: acc=%b", issue_accept);
    tick();
    clear_in();
    settle();
    chk("swap_cnt", outstanding, 4);
    chk("swap_busy", busy, 32'h0000_041C);
    chk("swap_full", full, 1);

    // WAW stall, then flush
    dst_addr = 5'd3; dst_we = 1'b1;
    #1;
    chk("waw_stall", stall, 1);
    issue_valid = 1'b1; issue_rd = 5'd11; flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_acc", issue_accept, 0);
    $display("waw x3 + flush: stall=%b acc=%b", stall, issue_accept);
    tick();
    clear_in();
    settle();
    chk("flush_busy", busy, 32'h0000_041C);
    chk("flush_cnt", outstanding, 4);

    // Completion for a non-busy register
    cmpl_valid = 1'b1; cmpl_rd = 5'd12;
    #1;
    chk("err_before", cmpl_err, 0);
    tick();
    clear_in();
    settle();
    chk("err_set", cmpl_err, 1);
    chk("err_cnt", outstanding, 4);
    $display("cmpl x12 not busy: err=%b cnt=%0d", cmpl_err, outstanding);

    // Reset mid-operation; comb path still sees the pending busy state
    rst = 1'b1; rs_addr = {5'd0, 5'd3}; rs_used = 2'b01;
    #1;
    chk("rst_comb_stall", stall, 1);
    tick();
    clear_in(); rst = 1'b0;
    settle();
    chk("rst2_busy", busy, 0);
    chk("rst2_cnt", outstanding, 0);
    chk("rst2_full", full, 0);
    chk("rst2_err", cmpl_err, 0);
    $display("reset mid-op: busy=%h cnt=%0d err=%b", busy, outstanding, cmpl_err);
    tick();

    // Randomized cycles against the model
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < NP; p++) rs_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int k = 0; k < NS; k++) stg_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      rs_used     = NP'($urandom);
      stg_we      = NS'($urandom);
      stg_valid   = NS'($urandom);
      stg_rdy     = NS'($urandom);
      dst_addr    = AW'($urandom_range(0, 7));
      dst_we      = ($urandom_range(0, 3) == 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd    = AW'($urandom_range(0, 7));
      cmpl_valid  = ($urandom_range(0, 2) == 0);
      cmpl_rd     = AW'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 59) == 0);
      settle();
      model_comb(e_sel, e_stall, e_acc);
      chk("rnd_sel", fwd_sel, e_sel);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_acc", issue_accept, e_acc);
      chk("rnd_busy", busy, m_busy_vec());
      chk("rnd_cnt", outstanding, m_count());
      chk("rnd_full", full, m_count() == MO);
      chk("rnd_err", cmpl_err, m_err);
      $display("rnd %0d: sel=%h stall=%b acc=%b cnt=%0d busy=%h", n, fwd_sel, stall,
               issue_accept, outstanding, busy);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
